// File: rtl/plank_uart_responder.sv
// plank_uart_responder
//   Model of one antenna plank on its serial link to the ACU/plank UART
//   controller. Command frames arrive as 8N1 bytes on i_rx_serial:
//     0xAA, CMD, payload, CHK, 0x55   (CHK = XOR of header, CMD and payload)
//   CMD[3:0] = 2: CONFIG, 17 payload bytes latched into cfg_store_q, ACK reply
//   CMD[3:0] = 3: STATUS, no payload, reply carries the telemetry word temp
//   Replies leave on o_tx_serial. A second valid frame that completes while a
//   reply is on the wire is held in a one-deep queue; further frames are dropped.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous reset, active high
//   i_rx_serial  command line from the controller, idle high
//   o_tx_serial  reply line to the controller, idle high
module plank_uart_responder #(
  parameter logic [23:0] temp         = 24'h000000,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx_serial,
  output logic o_tx_serial
);

  localparam int unsigned HalfBit  = CLKS_PER_BIT / 2;
  localparam int unsigned ToutClks = 40 * CLKS_PER_BIT;
  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned ToutW    = $clog2(ToutClks + 1);
  localparam int unsigned CfgBytes = 17;

  localparam logic [7:0] Hdr      = 8'hAA;
  localparam logic [7:0] Ftr      = 8'h55;
  localparam logic [7:0] AckCode  = 8'hEE;
  localparam logic [7:0] StatCode = 8'h13;
  localparam logic [7:0] AckChk   = Hdr ^ AckCode;
  localparam logic [7:0] StatChk  = Hdr ^ StatCode ^ temp[23:16] ^ temp[15:8] ^ temp[7:0];

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_ferr_q, rx_ferr_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= i_rx_serial;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == CntW'(HalfBit - 1)) begin
          // Line back high at mid start bit: glitch, not a start.
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
          // Return at mid stop bit so the next falling edge is never missed.
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
          if (rx_sync_q) begin
            rx_valid_d = 1'b1;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    StWaitHdr, StGetCmd, StGetPayload, StGetChk, StGetFtr
  } parse_state_e;

  parse_state_e     ps_q, ps_d;
  logic [7:0]       chk_q, chk_d;
  logic [4:0]       pay_cnt_q, pay_cnt_d;
  logic             is_cfg_q, is_cfg_d;
  logic [ToutW-1:0] tout_cnt_q;
  logic             tout_hit;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_ack_q, frame_ack_d;
  logic             stage_we, commit;
  logic [7:0]       stage_q     [CfgBytes];
  logic [7:0]       cfg_store_q [CfgBytes];

  assign tout_hit = (tout_cnt_q == ToutW'(ToutClks));

  always_comb begin
    ps_d        = ps_q;
    chk_d       = chk_q;
    pay_cnt_d   = pay_cnt_q;
    is_cfg_d    = is_cfg_q;
    frame_ok_d  = 1'b0;
    frame_ack_d = frame_ack_q;
    stage_we    = 1'b0;
    commit      = 1'b0;
    if (rx_ferr_q || tout_hit) begin
      ps_d = StWaitHdr;
    end else if (rx_valid_q) begin
      unique case (ps_q)
        StWaitHdr: begin
          if (rx_shift_q == Hdr) begin
            ps_d  = StGetCmd;
            chk_d = Hdr;
          end
        end
        StGetCmd: begin
          chk_d     = chk_q ^ rx_shift_q;
          pay_cnt_d = '0;
          if (rx_shift_q[3:0] == 4'h2) begin
            is_cfg_d = 1'b1;
            ps_d     = StGetPayload;
          end else if (rx_shift_q[3:0] == 4'h3) begin
            is_cfg_d = 1'b0;
            ps_d     = StGetChk;
          end else begin
            ps_d = StWaitHdr;
          end
        end
        StGetPayload: begin
          chk_d    = chk_q ^ rx_shift_q;
          stage_we = 1'b1;
          if (pay_cnt_q == 5'(CfgBytes - 1)) begin
            ps_d = StGetChk;
          end else begin
            pay_cnt_d = pay_cnt_q + 5'd1;
          end
        end
        StGetChk: begin
          ps_d = (rx_shift_q == chk_q) ? StGetFtr : StWaitHdr;
        end
        StGetFtr: begin
          ps_d = StWaitHdr;
          if (rx_shift_q == Ftr) begin
            frame_ok_d  = 1'b1;
            frame_ack_d = is_cfg_q;
            commit      = is_cfg_q;
          end
        end
        default: ps_d = StWaitHdr;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ps_q        <= StWaitHdr;
      chk_q       <= '0;
      pay_cnt_q   <= '0;
      is_cfg_q    <= 1'b0;
      tout_cnt_q  <= '0;
      frame_ok_q  <= 1'b0;
      frame_ack_q <= 1'b0;
      for (int i = 0; i < CfgBytes; i++) begin
        cfg_store_q[i] <= '0;
      end
    end else begin
      ps_q        <= ps_d;
      chk_q       <= chk_d;
      pay_cnt_q   <= pay_cnt_d;
      is_cfg_q    <= is_cfg_d;
      frame_ok_q  <= frame_ok_d;
      frame_ack_q <= frame_ack_d;
      // Counts line-idle clocks between bytes of a partial frame only.
      if (ps_q == StWaitHdr || rx_state_q != RxIdle) begin
        tout_cnt_q <= '0;
      end else if (!tout_hit) begin
        tout_cnt_q <= tout_cnt_q + 1'b1;
      end
      if (commit) begin
        for (int i = 0; i < CfgBytes; i++) begin
          cfg_store_q[i] <= stage_q[i];
        end
      end
    end
  end

  // Payload is staged so a frame that later fails CHK/footer leaves the store intact.
  always_ff @(posedge i_clk) begin
    if (stage_we) begin
      stage_q[pay_cnt_q] <= rx_shift_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Reply transmitter
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] reply_byte(input logic ack, input logic [2:0] idx);
    logic [7:0] b;
    b = Ftr;
    if (ack) begin
      case (idx)
        3'd0:    b = Hdr;
        3'd1:    b = AckCode;
        3'd2:    b = AckChk;
        default: b = Ftr;
      endcase
    end else begin
      case (idx)
        3'd0:    b = Hdr;
        3'd1:    b = StatCode;
        3'd2:    b = temp[23:16];
        3'd3:    b = temp[15:8];
        3'd4:    b = temp[7:0];
        3'd5:    b = StatChk;
        default: b = Ftr;
      endcase
    end
    return b;
  endfunction

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [2:0]      tx_idx_q, tx_idx_d;
  logic            tx_ack_q, tx_ack_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_line_q, tx_line_d;
  logic            pend_valid_q, pend_valid_d;
  logic            pend_ack_q, pend_ack_d;
  logic [2:0]      tx_last;
  logic            tx_bit_end, reply_done, tx_go, tx_go_ack;

  assign tx_last     = tx_ack_q ? 3'd3 : 3'd6;
  assign o_tx_serial = tx_line_q;

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q;
    tx_bit_d     = tx_bit_q;
    tx_idx_d     = tx_idx_q;
    tx_ack_d     = tx_ack_q;
    tx_shift_d   = tx_shift_q;
    tx_line_d    = tx_line_q;
    pend_valid_d = pend_valid_q;
    pend_ack_d   = pend_ack_q;
    tx_go        = 1'b0;
    tx_go_ack    = 1'b0;
    tx_bit_end   = (tx_cnt_q == CntW'(CLKS_PER_BIT - 1));
    reply_done   = (tx_state_q == TxStop) && tx_bit_end && (tx_idx_q == tx_last);

    // A reply may start from idle or straight off the last stop bit of the
    // previous one, which keeps a queued reply back-to-back with no gap.
    if (tx_state_q == TxIdle || reply_done) begin
      if (pend_valid_q) begin
        tx_go        = 1'b1;
        tx_go_ack    = pend_ack_q;
        pend_valid_d = frame_ok_q;
        pend_ack_d   = frame_ack_q;
      end else if (frame_ok_q) begin
        tx_go     = 1'b1;
        tx_go_ack = frame_ack_q;
      end
    end else if (frame_ok_q && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_ack_d   = frame_ack_q;
    end

    unique case (tx_state_q)
      TxIdle: tx_line_d = 1'b1;
      TxStart: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = TxStop;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxStop: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_idx_q == tx_last) begin
            tx_state_d = TxIdle;
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = reply_byte(tx_ack_q, tx_idx_q + 3'd1);
            tx_line_d  = 1'b0;
            tx_state_d = TxStart;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase

    if (tx_go) begin
      tx_state_d = TxStart;
      tx_cnt_d   = '0;
      tx_idx_d   = '0;
      tx_ack_d   = tx_go_ack;
      tx_shift_d = reply_byte(tx_go_ack, 3'd0);
      tx_line_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_state_q   <= TxIdle;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_idx_q     <= '0;
      tx_ack_q     <= 1'b0;
      tx_shift_q   <= '0;
      tx_line_q    <= 1'b1;
      pend_valid_q <= 1'b0;
      pend_ack_q   <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_idx_q     <= tx_idx_d;
      tx_ack_q     <= tx_ack_d;
      tx_shift_q   <= tx_shift_d;
      tx_line_q    <= tx_line_d;
      pend_valid_q <= pend_valid_d;
      pend_ack_q   <= pend_ack_d;
    end
  end

endmodule

// File: tb/tb_plank_uart_responder.sv
// Bench for plank_uart_responder: drives command frames bit by bit, decodes
// the reply line and checks each reply byte against a queue of expected bytes.
module tb_plank_uart_responder;

  localparam logic [23:0] Temp = 24'h2050DD;
  localparam int          C    = 16;
  // Receiver sample of a stop bit: 2 synchronizer clocks, 1 edge-detect clock,
  // C/2 to mid start bit, 9*C more to mid stop bit. Reply starts 2 clocks later.
  localparam int unsigned Lat  = 3 + C / 2 + 9 * C + 2;

  logic clk;
  logic rst;
  logic rx;
  logic tx;

  plank_uart_responder #(
    .temp        (Temp),
    .CLKS_PER_BIT(C)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_serial(rx),
    .o_tx_serial(tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned low_cnt = 0;
  always @(negedge clk) if (tx !== 1'b1) low_cnt <= low_cnt + 1;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  sb[$];
  int unsigned starts[$];
  logic [7:0]  frm[$];
  int unsigned ftr_cyc;
  bit          mon_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reply decoder; a byte interrupted by reset is abandoned.
  initial begin : monitor
    logic [7:0] b;
    logic       stop;
    logic       ab;
    b = '0;
    stop = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        mon_busy = 1'b1;
        ab = 1'b0;
        starts.push_back(cyc);
        for (int k = 0; k < C / 2; k++) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
        end
        for (int i = 0; i < 9 && !ab; i++) begin
          for (int k = 0; k < C; k++) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
          end
          if (i < 8) b[i] = tx;
          else stop = tx;
        end
        if (!ab) begin
          check("reply_byte_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) check("reply_byte", {24'd0, b}, {24'd0, sb.pop_front()});
          check("reply_stop_bit", {31'd0, stop}, 32'd1);
        end
        while (tx !== 1'b1) @(negedge clk);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 rx = f[i];
      if (i == 0) ftr_cyc = cyc;
      repeat (C - 1) @(posedge clk);
    end
  endtask

  task automatic send_frame();
    for (int i = 0; i < frm.size(); i++) send_byte(frm[i]);
  endtask

  task automatic push_status();
    logic [7:0] chk;
    chk = 8'hAA ^ 8'h13 ^ Temp[23:16] ^ Temp[15:8] ^ Temp[7:0];
    sb.push_back(8'hAA);
    sb.push_back(8'h13);
    sb.push_back(Temp[23:16]);
    sb.push_back(Temp[15:8]);
    sb.push_back(Temp[7:0]);
    sb.push_back(chk);
    sb.push_back(8'h55);
  endtask

  task automatic build_cfg(input logic [7:0] cmd, input logic [7:0] pay, input logic bad_chk,
                           input logic [7:0] ftr);
    logic [7:0] chk;
    frm = {};
    frm.push_back(8'hAA);
    frm.push_back(cmd);
    chk = 8'hAA ^ cmd;
    for (int i = 0; i < 17; i++) begin
      frm.push_back(pay);
      chk = chk ^ pay;
    end
    frm.push_back(bad_chk ? ~chk : chk);
    frm.push_back(ftr);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_drained"}, sb.size(), 32'd0);
    repeat (4 * C) @(posedge clk);
  endtask

  task automatic check_store(input string tag, input logic [7:0] v);
    for (int i = 0; i < 17; i++) check(tag, {24'd0, dut.cfg_store_q[i]}, {24'd0, v});
  endtask

  initial begin : stim
    int unsigned base;
    int          n;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and long idle
    @(negedge clk);
    check("reset_tx_high", {31'd0, tx}, 32'd1);
    check_store("reset_store", 8'h00);
    base = low_cnt;
    repeat (3000) @(posedge clk);
    check("idle_no_activity", low_cnt - base, 32'd0);
    check("idle_no_bytes", starts.size(), 32'd0);

    // STATUS: content, latency and length
    starts.delete();
    push_status();
    frm = {8'hAA, 8'h03, 8'hAA ^ 8'h03, 8'h55};
    send_frame();
    wait_drain("status", 200 * C);
    check("status_nbytes", starts.size(), 32'd7);
    if (starts.size() == 7) begin
      check("status_latency", starts[0], ftr_cyc + Lat);
      check("status_length", starts[6] + 10 * C - starts[0], 32'(70 * C));
    end

    // CONFIG with upper CMD nibble set
    starts.delete();
    sb.push_back(8'hAA);
    sb.push_back(8'hEE);
    sb.push_back(8'hAA ^ 8'hEE);
    sb.push_back(8'h55);
    build_cfg(8'hE2, 8'h32, 1'b0, 8'h55);
    check("cfg_chk_byte", {24'd0, frm[19]}, 32'h7A);
    send_frame();
    wait_drain("config", 200 * C);
    check("config_nbytes", starts.size(), 32'd4);
    if (starts.size() == 4) check("config_latency", starts[0], ftr_cyc + Lat);
    check_store("config_store", 8'h32);

    // Bad checksum, then bad footer: no reply, store untouched
    starts.delete();
    build_cfg(8'hE2, 8'h5A, 1'b1, 8'h55);
    send_frame();
    repeat (100 * C) @(posedge clk);
    check("badchk_no_reply", starts.size(), 32'd0);
    check_store("badchk_store", 8'h32);
    build_cfg(8'hE2, 8'h5A, 1'b0, 8'h56);
    send_frame();
    repeat (100 * C) @(posedge clk);
    check("badftr_no_reply", starts.size(), 32'd0);
    check_store("badftr_store", 8'h32);

    // Unknown command
    frm = {8'hAA, 8'h07, 8'hAA ^ 8'h07, 8'h55};
    send_frame();
    repeat (100 * C) @(posedge clk);
    check("badcmd_no_reply", starts.size(), 32'd0);

    // Inter-byte timeout after CMD, then a good frame
    frm = {8'hAA, 8'h03};
    send_frame();
    repeat (60 * C) @(posedge clk);
    frm = {8'hAA ^ 8'h03, 8'h55};
    send_frame();
    repeat (100 * C) @(posedge clk);
    check("timeout_no_reply", starts.size(), 32'd0);
    push_status();
    frm = {8'hAA, 8'h03, 8'hAA ^ 8'h03, 8'h55};
    send_frame();
    wait_drain("after_timeout", 200 * C);
    check("after_timeout_nbytes", starts.size(), 32'd7);

    // Reset during the third reply byte
    starts.delete();
    sb.push_back(8'hAA);
    sb.push_back(8'h13);
    send_frame();
    n = 0;
    while (starts.size() < 3 && n < 100 * C) begin
      @(posedge clk);
      n++;
    end
    check("rst_third_byte_seen", 32'(starts.size() >= 3), 32'd1);
    repeat (3 * C) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_tx_high_next_clk", {31'd0, tx}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_queue_empty", sb.size(), 32'd0);
    check("rst_store_cleared", {24'd0, dut.cfg_store_q[0]}, 32'd0);
    base = low_cnt;
    repeat (100 * C) @(posedge clk);
    check("rst_no_resume", low_cnt - base, 32'd0);
    starts.delete();
    push_status();
    send_frame();
    wait_drain("after_reset", 200 * C);
    check("after_reset_nbytes", starts.size(), 32'd7);

    // Two frames back to back: second reply queued, no idle gap
    starts.delete();
    push_status();
    push_status();
    frm = {8'hAA, 8'h03, 8'hAA ^ 8'h03, 8'h55, 8'hAA, 8'h03, 8'hAA ^ 8'h03, 8'h55};
    send_frame();
    wait_drain("queued", 300 * C);
    check("queued_nbytes", starts.size(), 32'd14);
    if (starts.size() == 14) check("queued_back_to_back", starts[7] - starts[0], 32'(70 * C));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
